reg_to_axi_lite: RTL and testbench

// Bridge from a register-bus initiator to an AXI4-Lite subordinate; the reverse of the
//   AXI-Lite-to-regbus converter used on the peripheral clock domain.

---
 rtl/reg_to_axi_lite.sv | 246 ++++++++++++++++++++++++
 tb/tb_reg_to_axi_lite.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_to_axi_lite.sv
`default_nettype none
// ============================================================================
// Module   : reg_to_axi_lite
// Brief    : Single-outstanding bridge from a regbus initiator to an
//            AXI4-Lite subordinate. One regbus request maps to one AXI read
//            or write, answered by a one-cycle regbus ready beat.
// Revision : 1.0 - initial release
// ============================================================================

package reg_to_axi_lite_pkg;

    localparam int unsigned ADDR_WIDTH = 48;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef struct packed {
        addr_t addr;
        logic  write;
        data_t wdata;
        strb_t wstrb;
        logic  valid;
    } reg_req_t;

    typedef struct packed {
        data_t rdata;
        logic  error;
        logic  ready;
    } reg_rsp_t;

    typedef struct packed {
        addr_t      addr;
        logic [2:0] prot;
    } axi_ax_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
    } axi_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        data_t      data;
        logic [1:0] resp;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        logic   ar_ready;
        axi_r_t r;
        logic   r_valid;
    } axi_lite_rsp_t;

endpackage

module reg_to_axi_lite #(
    parameter int unsigned ADDR_WIDTH     = 48,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [2:0]  AXI_PROT       = 3'b000,
    parameter type         reg_req_t      = reg_to_axi_lite_pkg::reg_req_t,
    parameter type         reg_rsp_t      = reg_to_axi_lite_pkg::reg_rsp_t,
    parameter type         axi_lite_req_t = reg_to_axi_lite_pkg::axi_lite_req_t,
    parameter type         axi_lite_rsp_t = reg_to_axi_lite_pkg::axi_lite_rsp_t
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  reg_req_t      reg_req_i,
    output reg_rsp_t      reg_rsp_o,
    output axi_lite_req_t axi_lite_req_o,
    input  axi_lite_rsp_t axi_lite_rsp_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WR_B  = 3'd2,
        ST_RD_AR = 3'd3,
        ST_RD_R  = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_error;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_aw_valid;
    logic                    r_w_valid;
    logic                    r_b_ready;
    logic                    r_ar_valid;
    logic                    r_r_ready;
    logic                    r_rsp_ready;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_all;
    logic w_w_all;

    assign w_aw_hs  = r_aw_valid & axi_lite_rsp_i.aw_ready;
    assign w_w_hs   = r_w_valid  & axi_lite_rsp_i.w_ready;
    // Counts a handshake landing this cycle so a joint AW/W completion leaves WR at once
    assign w_aw_all = r_aw_done | w_aw_hs;
    assign w_w_all  = r_w_done  | w_w_hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rdata     <= '0;
            r_error     <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_b_ready   <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_r_ready   <= 1'b0;
            r_rsp_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (reg_req_i.valid) begin
                        r_addr    <= reg_req_i.addr;
                        r_wdata   <= reg_req_i.wdata;
                        r_wstrb   <= reg_req_i.wstrb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (reg_req_i.write) begin
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_state    <= ST_WR;
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_state    <= ST_RD_AR;
                        end
                    end
                end
                ST_WR: begin
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end
                    if (w_aw_all && w_w_all) begin
                        r_b_ready <= 1'b1;
                        r_state   <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (axi_lite_rsp_i.b_valid) begin
                        r_b_ready   <= 1'b0;
                        r_error     <= (axi_lite_rsp_i.b.resp != RESP_OKAY);
                        r_rdata     <= '0;
                        r_rsp_ready <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RD_AR: begin
                    if (axi_lite_rsp_i.ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (axi_lite_rsp_i.r_valid) begin
                        r_r_ready   <= 1'b0;
                        r_rdata     <= axi_lite_rsp_i.r.data;
                        r_error     <= (axi_lite_rsp_i.r.resp != RESP_OKAY);
                        r_rsp_ready <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    r_rsp_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_aw_valid  <= 1'b0;
                    r_w_valid   <= 1'b0;
                    r_b_ready   <= 1'b0;
                    r_ar_valid  <= 1'b0;
                    r_r_ready   <= 1'b0;
                    r_rsp_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        axi_lite_req_o          = '0;
        axi_lite_req_o.aw.addr  = r_addr;
        axi_lite_req_o.aw.prot  = AXI_PROT;
        axi_lite_req_o.aw_valid = r_aw_valid;
        axi_lite_req_o.w.data   = r_wdata;
        axi_lite_req_o.w.strb   = r_wstrb;
        axi_lite_req_o.w_valid  = r_w_valid;
        axi_lite_req_o.b_ready  = r_b_ready;
        axi_lite_req_o.ar.addr  = r_addr;
        axi_lite_req_o.ar.prot  = AXI_PROT;
        axi_lite_req_o.ar_valid = r_ar_valid;
        axi_lite_req_o.r_ready  = r_r_ready;
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = r_rdata;
        reg_rsp_o.error = r_error;
        reg_rsp_o.ready = r_rsp_ready;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_to_axi_lite.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_to_axi_lite
// Brief    : Self-checking bench for reg_to_axi_lite with a scripted
//            AXI-Lite subordinate and expectation queues.
// Revision : 1.0 - initial release
// ============================================================================

module tb_reg_to_axi_lite;
    import reg_to_axi_lite_pkg::*;

    typedef struct {
        bit          write;
        logic [47:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_st;
        int          w_st;
        int          b_st;
        int          ar_st;
        int          r_st;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
    } txn_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    reg_req_t      reg_req;
    reg_rsp_t      reg_rsp;
    axi_lite_req_t axi_req;
    axi_lite_rsp_t axi_rsp;

    int n_checks = 0;
    int n_fail   = 0;
    int n_aw_hs  = 0;
    int n_w_hs   = 0;
    int n_b_hs   = 0;
    int n_ar_hs  = 0;
    int n_r_hs   = 0;
    int n_ready  = 0;

    txn_t        txns[$];
    logic [47:0] exp_aw_q[$];
    logic [35:0] exp_w_q[$];
    logic [47:0] exp_ar_q[$];
    logic [32:0] exp_rsp_q[$];

    always #5 clk_i = ~clk_i;

    reg_to_axi_lite dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .reg_req_i      (reg_req),
        .reg_rsp_o      (reg_rsp),
        .axi_lite_req_o (axi_req),
        .axi_lite_rsp_i (axi_rsp)
    );

    function automatic txn_t mk(input bit wr, input logic [47:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int aws, input int ws, input int bs,
                                input int ars, input int rs, input logic [1:0] rsp,
                                input logic [31:0] rd, input int lat);
        txn_t t;
        t.write = wr; t.addr = a; t.data = d; t.strb = s;
        t.aw_st = aws; t.w_st = ws; t.b_st = bs; t.ar_st = ars; t.r_st = rs;
        t.resp = rsp; t.rdata = rd; t.lat = lat;
        return t;
    endfunction

    // Presents a request and records what the subordinate and initiator must see
    task automatic present(input txn_t t);
        reg_req.addr  = t.addr;
        reg_req.write = t.write;
        reg_req.wdata = t.data;
        reg_req.wstrb = t.strb;
        reg_req.valid = 1'b1;
        if (t.write) begin
            exp_aw_q.push_back(t.addr);
            exp_w_q.push_back({t.data, t.strb});
            exp_rsp_q.push_back({32'h0, t.resp != 2'b00});
        end else begin
            exp_ar_q.push_back(t.addr);
            exp_rsp_q.push_back({t.rdata, t.resp != 2'b00});
        end
    endtask

    // Runs the queued transactions; must be entered at a negedge with the DUT idle
    task automatic run_txns(input bit hold, input int abort_cyc);
        int cyc, t0, idx, n;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_vc, w_vc;
        bit aw_got, w_got, b_issued, b_pend, r_pend, prev_ready;
        txn_t cur;
        logic [32:0] er;
        logic [35:0] ew;
        logic [47:0] ea;
        n = txns.size();
        idx = 0; cyc = 0; t0 = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; aw_vc = 0; w_vc = 0;
        aw_got = 0; w_got = 0; b_issued = 0; b_pend = 0; r_pend = 0; prev_ready = 0;
        cur = txns[0];
        present(cur);
        while (idx < n && cyc < 400 && cyc != abort_cyc) begin
            if (reg_rsp.ready) begin
                n_ready++;
                n_checks++;
                if (prev_ready) begin
                    n_fail++;
                    $display("FAIL ready_pulse: ready high %0d cycles in a row, required 1", 2);
                end
                n_checks++;
                if (exp_rsp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: ready with no request outstanding");
                end else begin
                    er = exp_rsp_q.pop_front();
                    if (reg_rsp.rdata !== er[32:1]) begin
                        n_fail++;
                        $display("FAIL rsp_rdata: got %h required %h", reg_rsp.rdata, er[32:1]);
                    end
                    n_checks++;
                    if (reg_rsp.error !== er[0]) begin
                        n_fail++;
                        $display("FAIL rsp_error: got %b required %b", reg_rsp.error, er[0]);
                    end
                end
                n_checks++;
                if (cyc - t0 != cur.lat) begin
                    n_fail++;
                    $display("FAIL latency: got %0d required %0d", cyc - t0, cur.lat);
                end
                if (cur.write) begin
                    n_checks++;
                    if (aw_vc != cur.aw_st + 1) begin
                        n_fail++;
                        $display("FAIL aw_valid_cycles: got %0d required %0d", aw_vc, cur.aw_st + 1);
                    end
                    n_checks++;
                    if (w_vc != cur.w_st + 1) begin
                        n_fail++;
                        $display("FAIL w_valid_cycles: got %0d required %0d", w_vc, cur.w_st + 1);
                    end
                end
                idx++;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; aw_vc = 0; w_vc = 0;
                aw_got = 0; w_got = 0; b_issued = 0; b_pend = 0; r_pend = 0;
                if (idx < n) begin
                    cur = txns[idx];
                    present(cur);
                    t0 = cyc + 1;
                end else begin
                    reg_req.valid = 1'b0;
                end
            end else if (!hold && cyc == t0 + 1) begin
                // Scramble the live request: the bridge must only use its latched copy
                reg_req.addr  = ~cur.addr;
                reg_req.wdata = ~cur.data;
                reg_req.wstrb = ~cur.strb;
                reg_req.write = ~cur.write;
                reg_req.valid = 1'b0;
            end
            prev_ready = reg_rsp.ready;

            axi_rsp.aw_ready = axi_req.aw_valid && (aw_cnt >= cur.aw_st);
            if (axi_req.aw_valid) aw_vc++;
            if (axi_req.aw_valid && axi_rsp.aw_ready) begin
                n_aw_hs++; aw_got = 1; aw_cnt = 0;
                n_checks++;
                if (exp_aw_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_aw: addr %h", axi_req.aw.addr);
                end else begin
                    ea = exp_aw_q.pop_front();
                    if (axi_req.aw.addr !== ea || axi_req.aw.prot !== 3'b000) begin
                        n_fail++;
                        $display("FAIL aw_addr: got %h/%b required %h/000", axi_req.aw.addr, axi_req.aw.prot, ea);
                    end
                end
            end else if (axi_req.aw_valid) aw_cnt++;

            axi_rsp.w_ready = axi_req.w_valid && (w_cnt >= cur.w_st);
            if (axi_req.w_valid) w_vc++;
            if (axi_req.w_valid && axi_rsp.w_ready) begin
                n_w_hs++; w_got = 1; w_cnt = 0;
                n_checks++;
                if (exp_w_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_w: data %h", axi_req.w.data);
                end else begin
                    ew = exp_w_q.pop_front();
                    if ({axi_req.w.data, axi_req.w.strb} !== ew) begin
                        n_fail++;
                        $display("FAIL w_data: got %h/%h required %h/%h", axi_req.w.data, axi_req.w.strb, ew[35:4], ew[3:0]);
                    end
                end
            end else if (axi_req.w_valid) w_cnt++;

            axi_rsp.b_valid = b_pend && (b_cnt >= cur.b_st);
            axi_rsp.b.resp  = cur.resp;
            if (axi_req.b_ready) begin
                n_checks++;
                if (!b_pend) begin
                    n_fail++;
                    $display("FAIL b_ready_state: got 1 required 0");
                end
            end
            if (axi_rsp.b_valid && axi_req.b_ready) begin
                n_b_hs++; b_pend = 0;
            end else if (b_pend) b_cnt++;
            if (cur.write && aw_got && w_got && !b_issued) begin
                b_issued = 1; b_pend = 1; b_cnt = 0;
            end

            axi_rsp.ar_ready = axi_req.ar_valid && (ar_cnt >= cur.ar_st);
            if (axi_req.ar_valid && axi_rsp.ar_ready) begin
                n_ar_hs++; ar_cnt = 0;
                n_checks++;
                if (exp_ar_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ar: addr %h", axi_req.ar.addr);
                end else begin
                    ea = exp_ar_q.pop_front();
                    if (axi_req.ar.addr !== ea || axi_req.ar.prot !== 3'b000) begin
                        n_fail++;
                        $display("FAIL ar_addr: got %h/%b required %h/000", axi_req.ar.addr, axi_req.ar.prot, ea);
                    end
                end
            end else if (axi_req.ar_valid) ar_cnt++;

            axi_rsp.r_valid = r_pend && (r_cnt >= cur.r_st);
            axi_rsp.r.data  = cur.rdata;
            axi_rsp.r.resp  = cur.resp;
            if (axi_req.r_ready) begin
                n_checks++;
                if (!r_pend) begin
                    n_fail++;
                    $display("FAIL r_ready_state: got 1 required 0");
                end
            end
            if (axi_rsp.r_valid && axi_req.r_ready) begin
                n_r_hs++; r_pend = 0;
            end else if (r_pend) r_cnt++;
            if (axi_req.ar_valid && axi_rsp.ar_ready) begin
                r_pend = 1; r_cnt = 0;
            end

            @(negedge clk_i);
            cyc++;
        end
        if (cyc != abort_cyc) begin
            n_checks++;
            if (idx < n) begin
                n_fail++;
                $display("FAIL timeout: completed %0d of %0d transactions", idx, n);
            end
            n_checks++;
            if (exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rsp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: %0d expectations never met, required 0",
                         exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rsp_q.size());
            end
        end
        axi_rsp = '0;
        txns.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if ({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s_axi_handshake: got %b required 00000", tag,
                     {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready});
        end
        n_checks++;
        if (reg_rsp.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rsp_ready: got %b required 0", tag, reg_rsp.ready);
        end
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        reg_req = '0;
        axi_rsp = '0;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        n_checks++;
        if (reg_rsp.rdata !== 32'h0 || reg_rsp.error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h/%b required 00000000/0", reg_rsp.rdata, reg_rsp.error);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_write_basic();
        int aw0, w0, b0;
        aw0 = n_aw_hs; w0 = n_w_hs; b0 = n_b_hs;
        txns.push_back(mk(1, 48'h0000_0200_0000, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3));
        run_txns(0, -1);
        n_checks++;
        if (n_aw_hs - aw0 != 1 || n_w_hs - w0 != 1 || n_b_hs - b0 != 1) begin
            n_fail++;
            $display("FAIL write_basic_count: got %0d/%0d/%0d required 1/1/1", n_aw_hs - aw0, n_w_hs - w0, n_b_hs - b0);
        end
    endtask

    task automatic test_write_aw_stall();
        int b0;
        b0 = n_b_hs;
        txns.push_back(mk(1, 48'h0000_0200_0010, 32'hA5A5_0F0F, 4'h5, 4, 0, 0, 0, 0, 2'b00, 32'h0, 7));
        run_txns(0, -1);
        n_checks++;
        if (n_b_hs - b0 != 1) begin
            n_fail++;
            $display("FAIL aw_stall_b_count: got %0d required 1", n_b_hs - b0);
        end
    endtask

    task automatic test_read_wait();
        txns.push_back(mk(0, 48'h0000_0200_0004, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'hDEAD_BEEF, 5));
        txns.push_back(mk(0, 48'h0000_0300_0008, 32'h0, 4'h0, 0, 0, 0, 3, 0, 2'b00, 32'h0BAD_F00D, 6));
        run_txns(0, -1);
    endtask

    task automatic test_errors();
        txns.push_back(mk(0, 48'h0000_0200_0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'hBAD0_0001, 3));
        txns.push_back(mk(1, 48'h0000_0200_0024, 32'hCAFE_0000, 4'hC, 0, 2, 1, 0, 0, 2'b11, 32'h0, 6));
        run_txns(0, -1);
    endtask

    task automatic test_back_to_back();
        int aw0, w0, b0, rdy0;
        aw0 = n_aw_hs; w0 = n_w_hs; b0 = n_b_hs; rdy0 = n_ready;
        txns.push_back(mk(1, 48'h0000_0400_0000, 32'h1111_1111, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3));
        txns.push_back(mk(1, 48'h0000_0400_0004, 32'h2222_2222, 4'h3, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3));
        txns.push_back(mk(1, 48'h0000_0400_0008, 32'h3333_3333, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3));
        run_txns(1, -1);
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (n_aw_hs - aw0 != 3 || n_w_hs - w0 != 3 || n_b_hs - b0 != 3 || n_ready - rdy0 != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got aw%0d w%0d b%0d rdy%0d required 3 each",
                     n_aw_hs - aw0, n_w_hs - w0, n_b_hs - b0, n_ready - rdy0);
        end
        check_idle_outputs("b2b_after");
    endtask

    task automatic test_reset_mid();
        txns.push_back(mk(1, 48'h0000_0500_0000, 32'h5555_AAAA, 4'hF, 0, 0, 20, 0, 0, 2'b00, 32'h0, 3));
        run_txns(0, 2);
        n_checks++;
        if (axi_req.b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_b_ready: got %b required 1", axi_req.b_ready);
        end
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_rsp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        txns.push_back(mk(0, 48'h0000_0500_0004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h7777_0001, 3));
        run_txns(0, -1);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_aw_stall();
        test_read_wait();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
